sipo_deframer: RTL and testbench
================================

Name: sipo_deframer

Overview:
- Serial-in/parallel-out receiver that sits directly downstream of the team's right-shift PISO stage.
- Consumes the PISO's serial stream (LSB first, one bit per enabled clock) and reassembles n-bit words.
- Presents each word on a registered output with a valid/ready handshake.
- Flags words lost because the consumer stalled.

Parameters:
- n, 4, data word width in bits (n >= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset; one clock, reset asynchronous active-low.
- en  input  1  bit strobe; SI and start are sampled only when en=1.
- start  input  1  frame start; qualified by en; marks SI as bit 0 of a new word.
- SI  input  1  serial data in, LSB first.
- Q  output  n  assembled word; stable while valid=1.
- valid  output  1  Q holds an unconsumed word.
- ready  input  1  consumer accepts Q on a clock edge where valid=1 and ready=1.
- overrun  output  1  sticky: a completed word was dropped.
- clr_ovr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (async, reset_n=0):
  - State=IDLE, shift register=0, bit counter=0, Q=0, valid=0, overrun=0.
  - Reset mid-frame discards the partial word; no valid is produced from it.
- Shift register sh[n-1:0] shifts right: on an accepted bit, sh <= {SI, sh[n-1:1]}. After n bits, sh[0]=first bit received, which matches PISO output order.
- Bit counter cnt has width clog2(n+1) and counts received bits of the current frame.
- FSM states:
  - IDLE:
    - en&start: load the first bit, cnt<=1, go to SHIFT.
    - Bits with en=1, start=0: ignored.
  - SHIFT:
    - en=0: hold everything (stall, no timeout).
    - en=1, start=0: shift, cnt<=cnt+1.
    - en=1, start=1: restart frame; the partial word is discarded, the bit is loaded as bit 0, cnt<=1; no error flag.
    - Completion: the edge that accepts bit number n (cnt==n-1 with en=1, start=0). The assembled word {SI, sh[n-1:1]} is the completed word. Go to IDLE, cnt<=0.
- Output register update at completion:
  - valid=0, or valid=1&ready=1 on the same edge: Q <= completed word, valid stays/becomes 1. The simultaneous handoff is lossless with no bubble.
  - valid=1&ready=0: completed word dropped, Q unchanged, overrun<=1.
- Without completion: valid&ready clears valid next edge; Q keeps its last value.
- Latency: valid rises on the same edge that samples bit n, i.e. visible in the cycle after the last bit is presented. Back-to-back frames (start on the cycle after completion) are supported; throughput is one word per n enabled cycles.
- overrun:
  - Set as above.
  - Cleared by clr_ovr=1 on an edge.
  - Set and clear in the same cycle: set wins.
- Q, valid and overrun are all registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: SIPO_DEFRAMER_PARITY_EN.
- Defined:
  - Frame is n data bits followed by one even-parity bit; completion occurs on bit n+1, and cnt counts to n.
  - Extra output port par_err (1 bit), registered alongside Q. It is 1 when the XOR of the n data bits and the parity bit is 1.
  - par_err updates only when Q updates; it is reset to 0.
  - A word with a parity error is still delivered with valid=1.
  - Overrun rules are unchanged, and a dropped word does not touch par_err.
- Undefined: frame is n bits, no par_err port, cnt counts to n-1.

Test Plan:
- Basic frame, n=4, ready=1: start+en with SI sequence 1,0,1,1 over 4 cycles → Q=4'b1101, valid=1 for exactly one cycle, overrun=0.
- Loopback: PISO loads I=4'hA and its SO is driven into SI with start on the first bit → Q=4'hA.
- Stall then overrun:
  - ready=0, send 4'h3 then 4'h5 back to back → Q=4'h3, valid stays 1, overrun=1 after the second frame.
  - Pulse clr_ovr → overrun=0.
  - ready=1 → valid drops.
- Simultaneous handoff: valid=1 holding 4'h3; ready=1 on the edge completing 4'h9 → Q=4'h9, valid=1, overrun=0.
- en gaps and restart:
  - Insert en=0 cycles between the bits of 4'h6 → Q=4'h6.
  - Assert start after 2 bits of a frame, then send 4'hC → only 4'hC delivered.
- Async reset: reset_n low mid-frame after 2 bits → all outputs 0 immediately. A fresh frame 4'hF after release → Q=4'hF.
- Parity (SIPO_DEFRAMER_PARITY_EN defined):
  - Data 4'b0111 with parity bit 1 → par_err=0.
  - Same data with parity bit 0 → par_err=1, valid=1.

Source files
------------

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer: rebuilds LSB-first words from a PISO stream
// and hands them off via valid/ready. Define SIPO_DEFRAMER_PARITY_EN for a trailing even-parity bit.
module sipo_deframer #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         start,
    input  logic         SI,
    output logic [n-1:0] Q,
    output logic         valid,
    input  logic         ready,
    output logic         overrun,
`ifdef SIPO_DEFRAMER_PARITY_EN
    output logic         par_err,
`endif
    input  logic         clr_ovr
);

    localparam int unsigned CW = $clog2(n + 1);
`ifdef SIPO_DEFRAMER_PARITY_EN
    localparam int unsigned FRAME = n + 1;
`else
    localparam int unsigned FRAME = n;
`endif
    localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t         state, state_nx;
    logic [n-1:0]   sh, sh_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [n-1:0]   q_nx;
    logic           valid_nx, ovr_nx;
    logic           complete;
    logic [n-1:0]   word;
`ifdef SIPO_DEFRAMER_PARITY_EN
    logic           perr, perr_nx;
`else
    // sh[0] is shifted out by the completing bit, so it is never observed here
    logic           unused_lsb;
    assign unused_lsb = sh[0];
`endif

    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        cnt_nx   = cnt;
        q_nx     = Q;
        valid_nx = valid;
        ovr_nx   = overrun;
        complete = 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
        word     = sh;
        perr     = ^{sh, SI};
        perr_nx  = par_err;
`else
        word     = {SI, sh[n-1:1]};
`endif

        case (state)
            IDLE: begin
                if (en && start) begin
                    sh_nx    = {SI, {(n-1){1'b0}}};
                    cnt_nx   = CW'(1);
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (en) begin
                    if (start) begin
                        sh_nx  = {SI, {(n-1){1'b0}}};
                        cnt_nx = CW'(1);
                    end else if (cnt == LAST) begin
                        complete = 1'b1;
                        cnt_nx   = '0;
                        state_nx = IDLE;
                    end else begin
                        sh_nx  = {SI, sh[n-1:1]};
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase

        // A completing word may replace Q in the same edge the old one is taken
        if (clr_ovr) ovr_nx = 1'b0;
        if (complete) begin
            if (!valid || ready) begin
                q_nx     = word;
                valid_nx = 1'b1;
`ifdef SIPO_DEFRAMER_PARITY_EN
                perr_nx  = perr;
`endif
            end else begin
                ovr_nx = 1'b1;
            end
        end else if (valid && ready) begin
            valid_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            Q       <= '0;
            valid   <= 1'b0;
            overrun <= 1'b0;
`ifdef SIPO_DEFRAMER_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            sh      <= sh_nx;
            cnt     <= cnt_nx;
            Q       <= q_nx;
            valid   <= valid_nx;
            overrun <= ovr_nx;
`ifdef SIPO_DEFRAMER_PARITY_EN
            par_err <= perr_nx;
`endif
        end
    end

endmodule

// File: tb/tb_sipo_deframer.sv
// Directed bench for sipo_deframer (n=4): expected words are queued as frames are
// sent and popped when the deframer presents them.
module tb_sipo_deframer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         start = 1'b0;
    logic         SI = 1'b0;
    logic         ready = 1'b0;
    logic         clr_ovr = 1'b0;
    logic [N-1:0] Q;
    logic         valid;
    logic         overrun;
`ifdef SIPO_DEFRAMER_PARITY_EN
    logic         par_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [N-1:0] exp_q[$];

    sipo_deframer #(.n(N)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .start   (start),
        .SI      (SI),
        .Q       (Q),
        .valid   (valid),
        .ready   (ready),
        .overrun (overrun),
`ifdef SIPO_DEFRAMER_PARITY_EN
        .par_err (par_err),
`endif
        .clr_ovr (clr_ovr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag);
        logic [N-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed=%0h expected=<empty scoreboard>", tag, Q);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(Q), 32'(e));
            check({tag, "_valid"}, 32'(valid), 32'd1);
        end
    endtask

    task automatic bit_in(input logic s, input logic b);
        en = 1'b1; start = s; SI = b;
        tick();
    endtask

    // rl/cl are the ready and clr_ovr levels held during the frame's final bit
    task automatic send(input logic [N-1:0] d, input bit gaps, input logic pbit,
                        input logic rl, input logic cl);
        for (int i = 0; i < N; i++) begin
`ifndef SIPO_DEFRAMER_PARITY_EN
            if (i == N-1) begin ready = rl; clr_ovr = cl; end
`endif
            bit_in(i == 0, d[i]);
            if (gaps && i < N-1) begin
                en = 1'b0; start = 1'b0; SI = ~SI;
                tick();
                check("gap_no_valid", 32'(valid), 32'd0);
            end
        end
`ifdef SIPO_DEFRAMER_PARITY_EN
        ready = rl; clr_ovr = cl;
        bit_in(1'b0, pbit);
`endif
        en = 1'b0; start = 1'b0; SI = 1'b0; clr_ovr = 1'b0;
    endtask

    initial begin
        logic [N-1:0] piso;

        tick();
        check("reset_Q", 32'(Q), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
`ifdef SIPO_DEFRAMER_PARITY_EN
        check("reset_par_err", 32'(par_err), 32'd0);
`endif
        #3 reset_n = 1'b1;
        tick();

        // basic frame: bits 1,0,1,1 -> 4'b1101
        ready = 1'b1;
        exp_q.push_back(4'b1101);
        send(4'b1101, 1'b0, 1'b1, 1'b1, 1'b0);
        check_word("basic");
        check("basic_overrun", 32'(overrun), 32'd0);
        tick();
        check("basic_valid_one_cycle", 32'(valid), 32'd0);

        // loopback from a right-shift PISO model loaded with 4'hA
        piso = 4'hA;
        exp_q.push_back(4'hA);
        for (int i = 0; i < N; i++) begin
`ifndef SIPO_DEFRAMER_PARITY_EN
            ready = 1'b1;
`endif
            bit_in(i == 0, piso[0]);
            piso = piso >> 1;
        end
`ifdef SIPO_DEFRAMER_PARITY_EN
        bit_in(1'b0, 1'b0);
`endif
        en = 1'b0; start = 1'b0;
        check_word("loopback");
        tick();

        // stall: 3 held, 5 dropped with clr_ovr on the same edge (set wins)
        ready = 1'b0;
        exp_q.push_back(4'h3);
        send(4'h3, 1'b0, 1'b0, 1'b0, 1'b0);
        check_word("stall_first");
        send(4'h5, 1'b0, 1'b0, 1'b0, 1'b1);
        check("stall_Q_held", 32'(Q), 32'h3);
        check("stall_valid_held", 32'(valid), 32'd1);
        check("overrun_set_wins", 32'(overrun), 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'd0);
        check("clr_keeps_Q", 32'(Q), 32'h3);

        // simultaneous handoff: ready rises only on the edge completing 9
        exp_q.push_back(4'h9);
        send(4'h9, 1'b0, 1'b0, 1'b1, 1'b0);
        check_word("handoff");
        check("handoff_overrun", 32'(overrun), 32'd0);
        tick();
        check("handoff_drain", 32'(valid), 32'd0);

        // en gaps inside a frame
        exp_q.push_back(4'h6);
        send(4'h6, 1'b1, 1'b0, 1'b1, 1'b0);
        check_word("en_gaps");
        tick();

        // restart after two bits; only C should appear, then hold it for the reset test
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        en = 1'b0; start = 1'b0;
        check("restart_partial_no_valid", 32'(valid), 32'd0);
        exp_q.push_back(4'hC);
        send(4'hC, 1'b0, 1'b0, 1'b0, 1'b0);
        check_word("restart");

        // make overrun sticky, then async reset mid-frame
        send(4'h1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_reset_overrun", 32'(overrun), 32'd1);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("async_Q", 32'(Q), 32'd0);
        check("async_valid", 32'(valid), 32'd0);
        check("async_overrun", 32'(overrun), 32'd0);
        en = 1'b0; start = 1'b0;
        tick();
        #3 reset_n = 1'b1;
        ready = 1'b1;
        // leftover bits without start must not form a word
        bit_in(1'b0, 1'b1);
        bit_in(1'b0, 1'b1);
        en = 1'b0;
        tick();
        check("post_reset_no_valid", 32'(valid), 32'd0);
        exp_q.push_back(4'hF);
        send(4'hF, 1'b0, 1'b0, 1'b1, 1'b0);
        check_word("after_reset");
        tick();

`ifdef SIPO_DEFRAMER_PARITY_EN
        exp_q.push_back(4'b0111);
        send(4'b0111, 1'b0, 1'b1, 1'b1, 1'b0);
        check_word("parity_ok");
        check("parity_ok_err", 32'(par_err), 32'd0);
        tick();
        exp_q.push_back(4'b0111);
        send(4'b0111, 1'b0, 1'b0, 1'b1, 1'b0);
        check_word("parity_bad");
        check("parity_bad_err", 32'(par_err), 32'd1);
        tick();
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
